// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the UART baud-rate generator slice.
//   baud_sel_t : 3-bit index into the standard baud-rate table
//   BAUD       : the eight selectable standard rates in bits per second
//   calc_incr  : phase-accumulator increment for a given rate, computed
//                with 64-bit arithmetic and round-to-nearest so it can be
//                used for elaboration-time constants
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef logic [2:0] baud_sel_t;

    localparam int NUM_RATES = 8;

    // Standard rates, indexed by baud_sel.
    localparam logic [63:0] BAUD [NUM_RATES] = '{
        64'd4800,
        64'd9600,
        64'd14400,
        64'd19200,
        64'd38400,
        64'd57600,
        64'd115200,
        64'd230400
    };

    // round(baud * os * 2^acc_w / clk_freq). Adding half the divisor before
    // the integer divide turns truncation into rounding to nearest.
    function automatic logic [63:0] calc_incr(
        input logic [63:0] baud,
        input logic [63:0] os,
        input logic [63:0] acc_w,
        input logic [63:0] clk_freq
    );
        logic [63:0] num;
        num = (baud * os) << acc_w;
        return (num + (clk_freq >> 1)) / clk_freq;
    endfunction

endpackage

// File: rtl/uart_nco.sv
// ---------------------------------------------------------------------------
// uart_nco
//
// Fractional phase accumulator (numerically controlled oscillator). Each
// enabled cycle adds incr to the accumulator modulo 2^ACC_W; the carry out
// of that add marks one oversample period.
//
// Ports:
//   clk    : system clock
//   rst    : synchronous active-high reset, clears the accumulator
//   clear  : synchronous phase clear (rate change, reload, resync)
//   en     : advance the phase this cycle
//   incr   : phase increment per cycle
//   carry  : high in the cycle whose add overflows (gated by en and clear)
// ---------------------------------------------------------------------------
module uart_nco #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [ACC_W-1:0] incr,
    output logic             carry
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    // One extra bit on the adder so the overflow is visible as the carry;
    // dropping that bit when storing gives the modulo-2^ACC_W wrap.
    always_comb begin
        sum = {1'b0, acc} + {1'b0, incr};
    end

    // A clear wins over enable so the phase restarts from exactly zero and
    // the first period after a clear is a full ceil(2^ACC_W/incr) cycles.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum[ACC_W-1:0];
        end
    end

    // The carry is only meaningful when the add is actually committed.
    assign carry = sum[ACC_W] & en & ~clear;

endmodule

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
//
// Run-time selectable UART baud-rate generator built on a fractional phase
// accumulator, so the rate error stays tiny at any clock frequency.
//
// Parameters:
//   CLK_FREQ   : input clock frequency in Hz
//   OVERSAMPLE : rx_ticks per bit period (must be >= 2)
//   ACC_W      : phase accumulator width in bits
//
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   en       : tick generation enable (phase holds while low)
//   baud_sel : index into uart_pkg::BAUD, changes take effect next cycle
//   resync   : one-cycle strobe, realigns the phase to zero
//   rx_tick  : one-cycle pulse at OVERSAMPLE x baud
//   tx_tick  : one-cycle pulse at baud, always coincident with an rx_tick
//   os_phase : current oversample index 0..OVERSAMPLE-1
//
// Optional build macro UART_BRG_PROG_EN adds a programmable increment:
//   cfg_we   : load cfg_incr as the increment and clear the phase
//   cfg_incr : increment value, kept until the next rate change or reset
// ---------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int ACC_W      = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  baud_sel_t                     baud_sel,
    input  logic                          resync,
`ifdef UART_BRG_PROG_EN
    input  logic                          cfg_we,
    input  logic [ACC_W-1:0]              cfg_incr,
`endif
    output logic                          rx_tick,
    output logic                          tx_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    // Increment for every table rate, folded to constants at elaboration.
    localparam logic [63:0] INCR_TAB [NUM_RATES] = '{
        calc_incr(BAUD[0], 64'(OVERSAMPLE), 64'(ACC_W), 64'(CLK_FREQ)),
        calc_incr(BAUD[1], 64'(OVERSAMPLE), 64'(ACC_W), 64'(CLK_FREQ)),
        calc_incr(BAUD[2], 64'(OVERSAMPLE), 64'(ACC_W), 64'(CLK_FREQ)),
        calc_incr(BAUD[3], 64'(OVERSAMPLE), 64'(ACC_W), 64'(CLK_FREQ)),
        calc_incr(BAUD[4], 64'(OVERSAMPLE), 64'(ACC_W), 64'(CLK_FREQ)),
        calc_incr(BAUD[5], 64'(OVERSAMPLE), 64'(ACC_W), 64'(CLK_FREQ)),
        calc_incr(BAUD[6], 64'(OVERSAMPLE), 64'(ACC_W), 64'(CLK_FREQ)),
        calc_incr(BAUD[7], 64'(OVERSAMPLE), 64'(ACC_W), 64'(CLK_FREQ))
    };

    localparam logic [ACC_W-1:0] INCR_RST = INCR_TAB[0][ACC_W-1:0];

    // An increment of zero never ticks and one of 2^ACC_W or more cannot be
    // represented, so either means the parameter set is unusable.
    for (genvar i = 0; i < NUM_RATES; i++) begin : g_incr_check
        if (INCR_TAB[i] == 64'd0 || INCR_TAB[i] >= (64'd1 << ACC_W)) begin : g_bad
            $error("uart_baud_gen: increment for rate %0d out of range", i);
        end
    end

    if (OVERSAMPLE < 2) begin : g_bad_os
        $error("uart_baud_gen: OVERSAMPLE must be at least 2");
    end

    baud_sel_t        sel_q;
    logic [ACC_W-1:0] incr_q;
    logic [OS_W-1:0]  os_cnt;
    logic             rate_change;
    logic             nco_clear;
    logic             carry;

    assign rate_change = (baud_sel != sel_q);

    // Anything that restarts the phase also clears the accumulator, so the
    // accumulator and the oversample counter always restart together.
`ifdef UART_BRG_PROG_EN
    assign nco_clear = rate_change | cfg_we | resync;
`else
    assign nco_clear = rate_change | resync;
`endif

    uart_nco #(
        .ACC_W (ACC_W)
    ) u_nco (
        .clk   (clk),
        .rst   (rst),
        .clear (nco_clear),
        .en    (en),
        .incr  (incr_q),
        .carry (carry)
    );

    // Rate selection, oversample counting and the tick registers. Ticks
    // default low every cycle so each pulse lasts exactly one cycle. The
    // if/else chain encodes the precedence rst > rate change > (reload) >
    // resync > normal counting; carry is already gated by en and clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= '0;
            incr_q  <= INCR_RST;
            os_cnt  <= '0;
            rx_tick <= 1'b0;
            tx_tick <= 1'b0;
        end else begin
            rx_tick <= 1'b0;
            tx_tick <= 1'b0;
            if (rate_change) begin
                sel_q  <= baud_sel;
                incr_q <= INCR_TAB[baud_sel][ACC_W-1:0];
                os_cnt <= '0;
`ifdef UART_BRG_PROG_EN
            end else if (cfg_we) begin
                incr_q <= cfg_incr;
                os_cnt <= '0;
`endif
            end else if (resync) begin
                os_cnt <= '0;
            end else if (carry) begin
                rx_tick <= 1'b1;
                if (os_cnt == OS_LAST) begin
                    os_cnt  <= '0;
                    tx_tick <= 1'b1;
                end else begin
                    os_cnt <= os_cnt + 1'b1;
                end
            end
        end
    end

    // The oversample counter is itself a register, so it is exported as is.
    assign os_phase = os_cnt;

endmodule

// File: tb/tb_uart_baud_gen.sv
// ---------------------------------------------------------------------------
// tb_uart_baud_gen
//
// Self-checking bench for uart_baud_gen at the default parameters. The
// reference model tracks how many enabled cycles have elapsed since the last
// phase restart and derives tick count, tick presence and oversample phase
// from floor(n * incr / 2^ACC_W).
// ---------------------------------------------------------------------------
module tb_uart_baud_gen;

    localparam int CLK_FREQ = 10_000_000;
    localparam int OS       = 16;
    localparam int ACC_W    = 24;
    localparam longint unsigned TWO_W = 64'd1 << ACC_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [2:0]       baud_sel;
    logic             resync;
    logic             rx_tick;
    logic             tx_tick;
    logic [3:0]       os_phase;
`ifdef UART_BRG_PROG_EN
    logic             cfg_we;
    logic [ACC_W-1:0] cfg_incr;
`endif

    always #5 clk = ~clk;

    uart_baud_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (OS),
        .ACC_W      (ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .baud_sel (baud_sel),
        .resync   (resync),
`ifdef UART_BRG_PROG_EN
        .cfg_we   (cfg_we),
        .cfg_incr (cfg_incr),
`endif
        .rx_tick  (rx_tick),
        .tx_tick  (tx_tick),
        .os_phase (os_phase)
    );

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    // Reference model state.
    longint unsigned m_incr;
    longint unsigned m_n;
    logic [2:0]      m_sel;
    logic            m_rx;
    logic            m_tx;
    int              m_phase;

    // Window statistics used by the directed sections.
    int     win_rx;
    int     win_tx;
    longint last_rx;
    int     int_lo;
    int     int_hi;

    function automatic longint unsigned ref_incr(input int idx);
        longint unsigned b;
        case (idx)
            0: b = 4800;
            1: b = 9600;
            2: b = 14400;
            3: b = 19200;
            4: b = 38400;
            5: b = 57600;
            6: b = 115200;
            default: b = 230400;
        endcase
        return (b * OS * TWO_W + CLK_FREQ / 2) / CLK_FREQ;
    endfunction

    function automatic longint unsigned ticks_by(input longint unsigned n,
                                                 input longint unsigned incr);
        return (n * incr) / TWO_W;
    endfunction

    // Advance the reference model by one clock edge with the given inputs.
    task automatic updateModel(input logic r, input logic e, input logic [2:0] s,
                               input logic rs, input logic cw,
                               input logic [ACC_W-1:0] ci);
        longint unsigned now_t;
        longint unsigned prev_t;
        m_rx = 1'b0;
        m_tx = 1'b0;
        if (r) begin
            m_sel  = 3'd0;
            m_incr = ref_incr(0);
            m_n    = 0;
        end else if (s != m_sel) begin
            m_sel  = s;
            m_incr = ref_incr(int'(s));
            m_n    = 0;
        end else if (cw) begin
            m_incr = longint'(ci);
            m_n    = 0;
        end else if (rs) begin
            m_n = 0;
        end else if (e) begin
            m_n    = m_n + 1;
            now_t  = ticks_by(m_n, m_incr);
            prev_t = ticks_by(m_n - 1, m_incr);
            m_rx   = (now_t != prev_t);
            m_tx   = m_rx && ((now_t % OS) == 0);
        end
        m_phase = int'(ticks_by(m_n, m_incr) % OS);
    endtask

    task automatic checkOutput();
        checks++;
        assert (rx_tick === m_rx) else begin
            errors++;
            $error("[TB] FAIL rx_tick cycle %0d: got %b expected %b", cyc, rx_tick, m_rx);
        end
        checks++;
        assert (tx_tick === m_tx) else begin
            errors++;
            $error("[TB] FAIL tx_tick cycle %0d: got %b expected %b", cyc, tx_tick, m_tx);
        end
        checks++;
        assert (os_phase === 4'(m_phase)) else begin
            errors++;
            $error("[TB] FAIL os_phase cycle %0d: got %0d expected %0d", cyc, os_phase, m_phase);
        end
        if (tx_tick === 1'b1) begin
            checks++;
            assert (rx_tick === 1'b1) else begin
                errors++;
                $error("[TB] FAIL tx_with_rx cycle %0d: got rx_tick %b expected 1", cyc, rx_tick);
            end
            win_tx++;
        end
        if (rx_tick === 1'b1) begin
            win_rx++;
            if (last_rx >= 0 && int_lo > 0) begin
                checks++;
                assert ((cyc - last_rx) >= int_lo && (cyc - last_rx) <= int_hi) else begin
                    errors++;
                    $error("[TB] FAIL rx_interval cycle %0d: got %0d expected %0d..%0d",
                           cyc, cyc - last_rx, int_lo, int_hi);
                end
            end
            last_rx = cyc;
        end
    endtask

    // Drive one cycle of inputs, step the model, then sample #1 after the edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [2:0] s,
                                 input logic rs, input logic cw,
                                 input logic [ACC_W-1:0] ci);
        rst      = r;
        en       = e;
        baud_sel = s;
        resync   = rs;
`ifdef UART_BRG_PROG_EN
        cfg_we   = cw;
        cfg_incr = ci;
`endif
        updateModel(r, e, s, rs, cw, ci);
        @(posedge clk);
        #1;
        cyc++;
        checkOutput();
    endtask

    task automatic runCycles(input int n, input logic e, input logic [2:0] s);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, e, s, 1'b0, 1'b0, '0);
        end
    endtask

    task automatic startWindow(input int lo, input int hi);
        win_rx  = 0;
        win_tx  = 0;
        last_rx = -1;
        int_lo  = lo;
        int_hi  = hi;
    endtask

    initial begin
        logic            found;
        longint          mark;
        int              rxn;
        logic [3:0]      held_phase;
        logic            r_r;
        logic            r_e;
        logic            r_rs;
        logic            r_cw;
        logic [2:0]      r_s;
        logic [ACC_W-1:0] r_ci;
        longint unsigned first_gap;

        m_sel = 3'd0; m_incr = ref_incr(0); m_n = 0;
        m_rx = 1'b0; m_tx = 1'b0; m_phase = 0;
        startWindow(0, 0);

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 3'd1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 3'd1, 1'b0, 1'b0, '0);

        $display("[TB] rate accuracy at 9600");
        applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, '0);
        startWindow(65, 66);
        runCycles(40000, 1'b1, 3'd1);
        checks++;
        assert (win_rx >= 614 && win_rx <= 615) else begin
            errors++;
            $error("[TB] FAIL rx_count_9600: got %0d expected 614..615", win_rx);
        end
        checks++;
        assert (win_tx == 38) else begin
            errors++;
            $error("[TB] FAIL tx_count_9600: got %0d expected 38", win_tx);
        end

        $display("[TB] rate change 4800 -> 115200 -> 230400");
        applyStimulus(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, '0);
        startWindow(130, 131);
        runCycles(3000, 1'b1, 3'd0);
        applyStimulus(1'b0, 1'b1, 3'd6, 1'b0, 1'b0, '0);
        startWindow(5, 6);
        runCycles(500, 1'b1, 3'd6);
        applyStimulus(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, '0);
        startWindow(2, 3);
        runCycles(300, 1'b1, 3'd7);

        $display("[TB] resync at os_phase 9");
        applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, '0);
        startWindow(0, 0);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, '0);
            if (os_phase === 4'd9) found = 1'b1;
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("[TB] FAIL phase9_wait: got os_phase %0d expected 9 within 2000 cycles", os_phase);
        end
        applyStimulus(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, '0);
        mark  = cyc;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, '0);
            if (rx_tick === 1'b1) found = 1'b1;
        end
        checks++;
        assert (found && (cyc - mark) == 66) else begin
            errors++;
            $error("[TB] FAIL resync_first_rx: got %0d cycles expected 66", cyc - mark);
        end
        rxn   = 1;
        found = (tx_tick === 1'b1);
        for (int i = 0; i < 2000 && !found; i++) begin
            applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, '0);
            if (rx_tick === 1'b1) rxn++;
            if (tx_tick === 1'b1) found = 1'b1;
        end
        checks++;
        assert (found && rxn == 16) else begin
            errors++;
            $error("[TB] FAIL resync_first_tx: got tx on rx_tick %0d expected 16", rxn);
        end

        $display("[TB] enable low for 1000 cycles");
        runCycles(100, 1'b1, 3'd1);
        held_phase = os_phase;
        startWindow(0, 0);
        runCycles(1000, 1'b0, 3'd1);
        checks++;
        assert ((win_rx + win_tx) == 0) else begin
            errors++;
            $error("[TB] FAIL disabled_ticks: got %0d ticks expected 0", win_rx + win_tx);
        end
        checks++;
        assert (os_phase === held_phase) else begin
            errors++;
            $error("[TB] FAIL disabled_phase: got %0d expected %0d", os_phase, held_phase);
        end
        runCycles(200, 1'b1, 3'd1);

        $display("[TB] reset together with resync and rate change");
        applyStimulus(1'b1, 1'b1, 3'd5, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, '0);
        mark      = cyc;
        first_gap = (TWO_W + ref_incr(5) - 1) / ref_incr(5);
        found     = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            applyStimulus(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, '0);
            if (rx_tick === 1'b1) found = 1'b1;
        end
        checks++;
        assert (found && longint'(cyc - mark) == longint'(first_gap)) else begin
            errors++;
            $error("[TB] FAIL post_reset_first_rx: got %0d cycles expected %0d", cyc - mark, first_gap);
        end

`ifdef UART_BRG_PROG_EN
        $display("[TB] programmable increment");
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, ACC_W'(1 << 23));
        startWindow(2, 2);
        runCycles(128, 1'b1, 3'd5);
        checks++;
        assert (win_tx == 4) else begin
            errors++;
            $error("[TB] FAIL cfg_tx_count: got %0d expected 4", win_tx);
        end
        applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, '0);
        startWindow(0, 0);
        runCycles(500, 1'b1, 3'd3);
`endif

        $display("[TB] randomized operation");
        startWindow(0, 0);
        r_s = 3'd2;
        for (int i = 0; i < 4000; i++) begin
            r_r  = ($urandom_range(0, 1499) == 0);
            r_e  = ($urandom_range(0, 9) != 0);
            r_rs = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) r_s = 3'($urandom_range(0, 7));
`ifdef UART_BRG_PROG_EN
            r_cw = ($urandom_range(0, 399) == 0);
            r_ci = ACC_W'($urandom_range(0, 1 << 23));
`else
            r_cw = 1'b0;
            r_ci = '0;
`endif
            applyStimulus(r_r, r_e, r_s, r_rs, r_cw, r_ci);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Parametrised successor to the fixed-divisor UART tick generator. It uses a fractional phase accumulator (NCO) so that baud error stays under 0.01 % at any clock frequency. It selects among 8 standard rates at run time and emits single-cycle pulses:
- rx_tick at OVERSAMPLE × baud
- tx_tick at 1 × baud
It also exports the oversample phase and accepts a resync strobe, so the RX start-bit detector can realign sampling. It sits between the clock domain root and the UART RX/TX engines.

Parameters:
- CLK_FREQ, 10_000_000: input clock frequency in Hz.
- OVERSAMPLE, 16: rx_ticks per bit. Must be ≥2.
- ACC_W, 24: phase accumulator width in bits.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: tick generation enable.
- baud_sel, input, 3: rate index into the package table.
- resync, input, 1: one-cycle strobe that realigns phase to zero.
- rx_tick, output, 1: one-cycle pulse at OVERSAMPLE × baud.
- tx_tick, output, 1: one-cycle pulse at baud.
- os_phase, output, $clog2(OVERSAMPLE): current oversample index.

Interface: one clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- Increment table: INCR[i] = round(BAUD[i]·OVERSAMPLE·2^ACC_W / CLK_FREQ). Compute with 64-bit elaboration arithmetic and rounding (+CLK_FREQ/2).
  - Elaboration error if any INCR ≥ 2^ACC_W or INCR == 0.
- Registers: acc[ACC_W-1:0], os_cnt, sel_q[2:0], incr_q[ACC_W-1:0], rx_tick, tx_tick.
- Reset values: acc=0, os_cnt=0, sel_q=0, incr_q=INCR[0], rx_tick=0, tx_tick=0, os_phase=0.
- Priority each cycle: rst > rate change > resync > en.
- Rate change (baud_sel != sel_q):
  - sel_q←baud_sel, incr_q←INCR[baud_sel].
  - acc←0, os_cnt←0.
  - rx_tick=tx_tick=0 this cycle.
  - The new rate applies from the next cycle.
- resync=1: acc←0, os_cnt←0, ticks 0 this cycle.
- en=0: acc and os_cnt hold; rx_tick=tx_tick=0.
- en=1 (normal): {carry, acc} ← acc + incr_q, with (ACC_W+1)-bit add and wrap-around modulo 2^ACC_W.
  - rx_tick ← carry, registered; a pulse is exactly 1 cycle.
  - On carry: os_cnt increments. If os_cnt == OVERSAMPLE-1, os_cnt←0 and tx_tick←1 in the same cycle as that rx_tick.
- Timing: first rx_tick after reset/resync/rate change occurs ceil(2^ACC_W/incr_q) cycles later.
  - tx_tick is only ever high together with rx_tick.
  - Consecutive rx_ticks are floor or ceil of 2^ACC_W/incr_q cycles apart.
- os_phase is os_cnt, registered.
- Reset mid-operation: all state returns to reset values next edge, and no tick is emitted in that cycle.

Optional Feature:
- Macro: UART_BRG_PROG_EN.
- Defined: adds input cfg_we (1 bit) and input cfg_incr (ACC_W bits).
  - cfg_we=1 loads incr_q←cfg_incr and clears acc and os_cnt (no ticks that cycle). This overrides the table until the next baud_sel change or reset.
  - Priority: rst > rate change > cfg_we > resync.
  - cfg_incr=0 stops ticks.
- Undefined: ports absent; incr_q comes only from the table.

Decomposition:
- Package uart_pkg holds:
  - BAUD table localparam array [0..7] = 4800, 9600, 14400, 19200, 38400, 57600, 115200, 230400.
  - Typedef baud_sel_t (3 bits).
  - Function calc_incr(baud, os, acc_w, clk_freq) returning a 64-bit result.
- Natural sub-module: uart_nco (acc + incr_q, with clear/enable, emitting carry).
- Top: select/reload logic, oversample counter, output registers.

Test Plan (defaults CLK_FREQ=1e7, OS=16, ACC_W=24):
- Rate accuracy: reset, baud_sel=1 (INCR=257698), en=1 for 160000 cycles.
  - rx_tick count 2457–2458, tx_tick count 153.
  - Every rx interval is 65 or 66 cycles; every 16th rx_tick has tx_tick=1 and os_phase wraps 15→0.
- Rate change: run sel=0 (INCR=128849), switch to sel=6 (INCR=3092376) mid-bit.
  - Next cycle: acc=0, os_phase=0, no tick.
  - Afterwards rx intervals are 5 or 6 cycles; 230400 (sel=7, INCR=6184753) gives intervals of 2 or 3.
- Resync: pulse resync when os_phase=9.
  - Next cycle os_phase=0, no tick.
  - First rx_tick exactly ceil(2^24/257698)=66 cycles later; tx_tick follows 16 rx_ticks later.
- Enable: en=0 for 1000 cycles.
  - Zero ticks; acc and os_phase frozen.
  - Resume continues the phase with no glitch pulse.
- Reset/simultaneity: assert rst together with resync and a baud_sel change mid-operation.
  - All outputs 0 next cycle, sel_q=0.
  - Then the sel change is applied on the following cycle.
- UART_BRG_PROG_EN: cfg_we with cfg_incr=2^23.
  - rx_tick every 2 cycles, tx_tick every 32 cycles.
  - A subsequent baud_sel change restores the table INCR.
